alu_arbiter: RTL and testbench

Shares one combinational ALU instance between two requesters (e.g. core pipeline and a debug/CSR engine) using a valid/ready handshake on the request side and a valid/ready response channel per port. Arbitration is round-robin by default, with an optional fixed priority for port 0. The block registers operands, drives the shared ALU for one cycle, and captures result `C` and flag `f` into a per-transaction response register. It sits between the requesters and the single ALU in mySoC.

---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 114 +++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the shared ALU and alu_arbiter.
// master: requester/ALU side; slave: the arbiter itself.
interface alu_arbiter_if;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        rsp0_valid, rsp0_ready, rsp0_f;
   logic        rsp1_valid, rsp1_ready, rsp1_f;
   logic [31:0] rsp0_c, rsp1_c;
   logic [31:0] alu_a, alu_b, alu_c;
   logic [3:0]  alu_op;
   logic        alu_f;
   logic        busy;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp0_ready, rsp1_ready, alu_c, alu_f,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_c, rsp0_f, rsp1_valid, rsp1_c, rsp1_f,
      input  alu_a, alu_b, alu_op, busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp0_ready, rsp1_ready, alu_c, alu_f,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_c, rsp0_f, rsp1_valid, rsp1_c, rsp1_f,
      output alu_a, alu_b, alu_op, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU.
// One transaction at a time: IDLE (grant/latch) -> EXEC (ALU driven) -> RESP
// (hold result until the owning port takes it). Operand registers drive the
// ALU directly, so alu_* keep their last latched value outside EXEC.
module alu_arbiter #(
   parameter bit PRIO_FIXED = 1'b0
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        gnt_id_q, gnt_id_d;
   logic [31:0] opnd_a_q, opnd_a_d, opnd_b_q, opnd_b_d;
   logic [3:0]  opnd_op_q, opnd_op_d;
   logic [31:0] res_c_q, res_c_d;
   logic        res_f_q, res_f_d;
   logic [1:0]  rsp_valid_q, rsp_valid_d;

   logic [1:0]  req_valid, rsp_ready, req_ready;
   logic        gnt_sel;

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

   // Grant: a lone requester wins; on contention port 0 (fixed) or the port
   // that did not complete last (round-robin). Ready only in IDLE, out of reset.
   always_comb begin
      if (&req_valid) gnt_sel = PRIO_FIXED ? 1'b0 : ~last_grant_q;
      else            gnt_sel = req_valid[1];
      req_ready = '0;
      if (state_q == IDLE && !rst) req_ready[gnt_sel] = req_valid[gnt_sel];
   end

   // Next-state and datapath for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_id_d     = gnt_id_q;
      opnd_a_d     = opnd_a_q;
      opnd_b_d     = opnd_b_q;
      opnd_op_d    = opnd_op_q;
      res_c_d      = res_c_q;
      res_f_d      = res_f_q;
      rsp_valid_d  = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (|req_ready) begin
               gnt_id_d  = gnt_sel;
               opnd_a_d  = gnt_sel ? bus.req1_a  : bus.req0_a;
               opnd_b_d  = gnt_sel ? bus.req1_b  : bus.req0_b;
               opnd_op_d = gnt_sel ? bus.req1_op : bus.req0_op;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            res_c_d               = bus.alu_c;
            res_f_d               = bus.alu_f;
            rsp_valid_d[gnt_id_q] = 1'b1;
            state_d               = RESP;
         end
         RESP: begin
            // last_grant moves only here, so an aborted transaction never counts
            if (rsp_ready[gnt_id_q]) begin
               rsp_valid_d  = '0;
               last_grant_d = gnt_id_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset drops any in-flight transaction immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         gnt_id_q     <= 1'b0;
         opnd_a_q     <= '0;
         opnd_b_q     <= '0;
         opnd_op_q    <= '0;
         res_c_q      <= '0;
         res_f_q      <= 1'b0;
         rsp_valid_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_id_q     <= gnt_id_d;
         opnd_a_q     <= opnd_a_d;
         opnd_b_q     <= opnd_b_d;
         opnd_op_q    <= opnd_op_d;
         res_c_q      <= res_c_d;
         res_f_q      <= res_f_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign bus.req0_ready = req_ready[0];
   assign bus.req1_ready = req_ready[1];
   assign bus.rsp0_valid = rsp_valid_q[0];
   assign bus.rsp1_valid = rsp_valid_q[1];
   assign bus.rsp0_c     = res_c_q;
   assign bus.rsp1_c     = res_c_q;
   assign bus.rsp0_f     = res_f_q;
   assign bus.rsp1_f     = res_f_q;
   assign bus.alu_a      = opnd_a_q;
   assign bus.alu_b      = opnd_b_q;
   assign bus.alu_op     = opnd_op_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance (index 0) and a fixed-priority
// instance (index 1) run side by side on the same clock, each with its own
// ALU model and requester stimulus, against a transaction-level reference.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // stimulus [dut][port]
   logic        s_v  [2][2];
   logic [31:0] s_a  [2][2];
   logic [31:0] s_b  [2][2];
   logic [3:0]  s_op [2][2];
   logic        s_rr [2][2];
   // observed outputs
   logic        o_rdy [2][2];
   logic        o_rv  [2][2];
   logic        o_f   [2][2];
   logic [31:0] o_c   [2][2];
   logic [31:0] o_aa  [2];
   logic [31:0] o_ab  [2];
   logic [3:0]  o_aop [2];
   logic        o_busy[2];

   // Shared ALU behaviour: {f, C}
   function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      logic [31:0] c;
      logic        f;
      case (op)
         4'd0: c = a + b;
         4'd1: c = a - b;
         4'd2: c = a & b;
         4'd3: c = a | b;
         4'd4: c = a ^ b;
         4'd5: c = a << b[4:0];
         4'd6: c = a >> b[4:0];
         4'd7: c = $signed(a) >>> b[4:0];
         4'd8: c = {31'd0, $signed(a) < $signed(b)};
         4'd9: c = {31'd0, a < b};
         default: c = a ^ ~b;
      endcase
      f = (op == 4'd8) ? ($signed(a) < $signed(b)) : (op == 4'd9) ? (a < b) : (a == b);
      return {f, c};
   endfunction

   alu_arbiter_if ifc [2] ();

   for (genvar d = 0; d < 2; d++) begin : g_dut
      assign ifc[d].req0_valid = s_v[d][0];
      assign ifc[d].req0_a     = s_a[d][0];
      assign ifc[d].req0_b     = s_b[d][0];
      assign ifc[d].req0_op    = s_op[d][0];
      assign ifc[d].req1_valid = s_v[d][1];
      assign ifc[d].req1_a     = s_a[d][1];
      assign ifc[d].req1_b     = s_b[d][1];
      assign ifc[d].req1_op    = s_op[d][1];
      assign ifc[d].rsp0_ready = s_rr[d][0];
      assign ifc[d].rsp1_ready = s_rr[d][1];
      assign {ifc[d].alu_f, ifc[d].alu_c} = alu_fn(ifc[d].alu_a, ifc[d].alu_b, ifc[d].alu_op);
      assign o_rdy[d][0] = ifc[d].req0_ready;
      assign o_rdy[d][1] = ifc[d].req1_ready;
      assign o_rv[d][0]  = ifc[d].rsp0_valid;
      assign o_rv[d][1]  = ifc[d].rsp1_valid;
      assign o_c[d][0]   = ifc[d].rsp0_c;
      assign o_c[d][1]   = ifc[d].rsp1_c;
      assign o_f[d][0]   = ifc[d].rsp0_f;
      assign o_f[d][1]   = ifc[d].rsp1_f;
      assign o_aa[d]     = ifc[d].alu_a;
      assign o_ab[d]     = ifc[d].alu_b;
      assign o_aop[d]    = ifc[d].alu_op;
      assign o_busy[d]   = ifc[d].busy;

      alu_arbiter #(.PRIO_FIXED(d == 1)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (ifc[d].slave)
      );
   end

   int n_chk, n_pass, e;
   bit rnd;

   // reference model: one outstanding transaction per instance
   bit          m_out  [2];
   bit          m_own  [2];
   int          m_T    [2];
   logic [31:0] m_c    [2];
   logic        m_f    [2];
   bit          m_last [2];
   logic [31:0] m_la   [2];
   logic [31:0] m_lb   [2];
   logic [3:0]  m_lop  [2];
   bit          hs_pend[2][2];
   bit          done_pend[2];
   bit          acc    [2][2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic int winner(input int d);
      if (s_v[d][0] && s_v[d][1]) return (d == 1) ? 0 : (m_last[d] ? 0 : 1);
      return s_v[d][1] ? 1 : 0;
   endfunction

   function automatic bit rv_exp(input int d, input int p);
      return m_out[d] && (int'(m_own[d]) == p) && (e >= m_T[d] + 1);
   endfunction

   task automatic gen();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            if (acc[d][p] || !s_v[d][p]) begin
               s_v[d][p]  = ($urandom_range(0, 1) == 1);
               s_a[d][p]  = $urandom;
               s_b[d][p]  = ($urandom_range(0, 3) == 0) ? s_a[d][p] : $urandom;
               s_op[d][p] = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 7) == 0) begin
               s_v[d][p] = 1'b0;
            end
            s_rr[d][p] = ($urandom_range(0, 3) != 0);
         end
   endtask

   // One clock: check grant against current inputs, advance, check outputs.
   task automatic cyc();
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            bit er;
            er = !m_out[d] && s_v[d][p] && (winner(d) == p);
            chk($sformatf("req_ready d%0d p%0d", d, p), o_rdy[d][p], er);
            hs_pend[d][p] = er;
         end
         done_pend[d] = m_out[d] && (e >= m_T[d] + 1) && s_rr[d][m_own[d]];
      end
      @(posedge clk);
      e++;
      #1;
      for (int d = 0; d < 2; d++) begin
         acc[d][0] = 1'b0;
         acc[d][1] = 1'b0;
         if (done_pend[d]) begin
            m_out[d]  = 1'b0;
            m_last[d] = m_own[d];
         end
         for (int p = 0; p < 2; p++)
            if (hs_pend[d][p]) begin
               m_out[d] = 1'b1;
               m_own[d] = (p == 1);
               m_T[d]   = e;
               {m_f[d], m_c[d]} = alu_fn(s_a[d][p], s_b[d][p], s_op[d][p]);
               m_la[d]  = s_a[d][p];
               m_lb[d]  = s_b[d][p];
               m_lop[d] = s_op[d][p];
               acc[d][p] = 1'b1;
            end
         chk($sformatf("busy d%0d", d), o_busy[d], m_out[d]);
         chk($sformatf("alu_a d%0d", d), o_aa[d], m_la[d]);
         chk($sformatf("alu_b d%0d", d), o_ab[d], m_lb[d]);
         chk($sformatf("alu_op d%0d", d), o_aop[d], m_lop[d]);
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("rsp_valid d%0d p%0d", d, p), o_rv[d][p], rv_exp(d, p));
            if (rv_exp(d, p)) begin
               chk($sformatf("rsp_c d%0d p%0d", d, p), o_c[d][p], m_c[d]);
               chk($sformatf("rsp_f d%0d p%0d", d, p), o_f[d][p], m_f[d]);
            end
         end
      end
      if (rnd) gen();
      else
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
               if (acc[d][p]) s_v[d][p] = 1'b0;
   endtask

   // Assert reset asynchronously with requests pending; outputs must clear at once.
   task automatic do_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) s_v[d][p] = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst busy d%0d", d), o_busy[d], 1'b0);
         chk($sformatf("rst alu_a d%0d", d), o_aa[d], 32'd0);
         chk($sformatf("rst alu_b d%0d", d), o_ab[d], 32'd0);
         chk($sformatf("rst alu_op d%0d", d), o_aop[d], 4'd0);
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst req_ready d%0d p%0d", d, p), o_rdy[d][p], 1'b0);
            chk($sformatf("rst rsp_valid d%0d p%0d", d, p), o_rv[d][p], 1'b0);
            chk($sformatf("rst rsp_c d%0d p%0d", d, p), o_c[d][p], 32'd0);
            chk($sformatf("rst rsp_f d%0d p%0d", d, p), o_f[d][p], 1'b0);
            hs_pend[d][p] = 1'b0;
            acc[d][p]     = 1'b0;
         end
         m_out[d] = 1'b0; m_last[d] = 1'b1; done_pend[d] = 1'b0;
         m_la[d] = '0; m_lb[d] = '0; m_lop[d] = '0;
      end
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            s_v[d][p]  = 1'b0;
            s_rr[d][p] = 1'b1;
         end
   endtask

   task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      for (int d = 0; d < 2; d++) begin
         s_v[d][p] = 1'b1; s_op[d][p] = op; s_a[d][p] = a; s_b[d][p] = b;
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0; e = 0; rnd = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            s_v[d][p] = 1'b0; s_a[d][p] = '0; s_b[d][p] = '0;
            s_op[d][p] = '0; s_rr[d][p] = 1'b1;
         end
      do_reset();

      // single ADD on port 0
      set_req(0, 4'd0, 32'd5, 32'd7);
      cyc();
      repeat (3) begin
         cyc();
         if (o_rv[0][0]) chk("add 5+7", o_c[0][0], 32'd12);
      end

      // simultaneous first request after reset: port 0 first, then port 1
      do_reset();
      set_req(0, 4'd1, 32'd10, 32'd3);
      set_req(1, 4'd7, 32'h8000_0000, 32'd4);
      repeat (8) begin
         cyc();
         if (o_rv[0][0]) chk("sub 10-3", o_c[0][0], 32'd7);
         if (o_rv[0][1]) chk("sar 0x80000000>>>4", o_c[0][1], 32'hF800_0000);
      end

      // response backpressure on port 0 with port 1 waiting
      for (int d = 0; d < 2; d++) s_rr[d][0] = 1'b0;
      set_req(0, 4'd4, 32'hDEAD_BEEF, 32'h1234_5678);
      set_req(1, 4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F);
      repeat (7) cyc();
      for (int d = 0; d < 2; d++) s_rr[d][0] = 1'b1;
      repeat (8) cyc();

      // reset while port 1 is in EXEC; next contention goes to port 0
      do_reset();
      set_req(1, 4'd0, 32'd100, 32'd200);
      cyc();
      do_reset();
      set_req(0, 4'd3, 32'hA5A5_0000, 32'h0000_5A5A);
      set_req(1, 4'd8, 32'hFFFF_FFFF, 32'd1);
      repeat (8) cyc();

      // randomized traffic, valid withdrawal and backpressure
      rnd = 1'b1;
      repeat (800) cyc();
      rnd = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
